// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin arbiter and sequencer for a byte-wide data memory.
// Each 32-bit word access becomes four little-endian byte beats; bad requests are acked with err.
module dmem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [31:0]       p0_wdata_i,
  output logic              p0_ack_o,
  output logic              p0_err_o,
  output logic [31:0]       p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_wdata_i,
  output logic              p1_ack_o,
  output logic              p1_err_o,
  output logic [31:0]       p1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  state_t            state, state_n;
  logic [1:0]        k, k_n;
  logic              grant, grant_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic              err_q, err_n;
  logic [23:0]       rbuf;
  logic [ADDR_W-1:0] mem_addr_n;
  logic              mem_write_n, mem_read_n;
  logic [7:0]        wbyte_n;
  logic [31:0]       rword;
  logic              load_rdata;
  logic              ack_n;
  logic              unused_rdata;

  // only the low byte of the memory read bus carries data
  assign unused_rdata = ^mem_rdata_i[31:8];
  assign rword        = {mem_rdata_i[7:0], rbuf};
  assign load_rdata   = (state == XFER) && (k == 2'd3) && !we_q;

  // Next state, grant/latch decisions and next values of the memory strobes
  always_comb begin
    state_n     = state;
    k_n         = k;
    grant_n     = grant;
    we_n        = we_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    err_n       = err_q;
    mem_addr_n  = '0;
    mem_write_n = 1'b0;
    mem_read_n  = 1'b0;
    wbyte_n     = '0;
    unique case (state)
      IDLE: begin
        if (p0_req_i || p1_req_i) begin
          grant_n = (p0_req_i && p1_req_i) ? ~grant : p1_req_i;
          we_n    = grant_n ? p1_we_i    : p0_we_i;
          addr_n  = grant_n ? p1_addr_i  : p0_addr_i;
          wdata_n = grant_n ? p1_wdata_i : p0_wdata_i;
          k_n     = '0;
          err_n   = (addr_n[1:0] != 2'b00) || (addr_n > MAX_ADDR);
          state_n = err_n ? DONE : XFER;
        end
      end
      XFER: begin
        if (k == 2'd3) state_n = DONE;
        else           k_n     = k + 2'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n == XFER) begin
      mem_addr_n  = addr_n + ADDR_W'(k_n);
      mem_write_n = we_n;
      mem_read_n  = !we_n;
      if (we_n) wbyte_n = wdata_n[{k_n, 3'b000} +: 8];
    end
  end

  assign ack_n = (state_n == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      k           <= '0;
      grant       <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rbuf        <= '0;
      mem_addr_o  <= '0;
      mem_write_o <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_wdata_o <= '0;
      busy_o      <= 1'b0;
      p0_ack_o    <= 1'b0;
      p0_err_o    <= 1'b0;
      p0_rdata_o  <= '0;
      p1_ack_o    <= 1'b0;
      p1_err_o    <= 1'b0;
      p1_rdata_o  <= '0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      grant       <= grant_n;
      we_q        <= we_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      err_q       <= err_n;
      mem_addr_o  <= mem_addr_n;
      mem_write_o <= mem_write_n;
      mem_read_o  <= mem_read_n;
      mem_wdata_o <= {24'b0, wbyte_n};
      busy_o      <= (state_n != IDLE);
      p0_ack_o    <= ack_n && !grant_n;
      p0_err_o    <= ack_n && !grant_n && err_n;
      p1_ack_o    <= ack_n && grant_n;
      p1_err_o    <= ack_n && grant_n && err_n;
      // read bytes arrive in order k=0..3, so a shift register assembles the word
      if (state == XFER && !we_q) rbuf <= {mem_rdata_i[7:0], rbuf[23:8]};
      if (load_rdata && !grant) p0_rdata_o <= rword;
      if (load_rdata &&  grant) p1_rdata_o <= rword;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte memory model, beat monitor and per-port expectation queues.
module tb_dmem_access_ctrl;
  localparam int unsigned MEM_BYTES = 32;
  localparam int unsigned ADDR_W    = 32;

  typedef struct { logic err; logic [31:0] rdata; } exp_t;
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [7:0] data; } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i;
  logic p0_req_i, p0_we_i, p0_ack_o, p0_err_o;
  logic [31:0] p0_addr_i, p0_wdata_i, p0_rdata_o;
  logic p1_req_i, p1_we_i, p1_ack_o, p1_err_o;
  logic [31:0] p1_addr_i, p1_wdata_i, p1_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic mem_write_o, mem_read_o, busy_o;

  dmem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_ack_o(p0_ack_o), .p0_err_o(p0_err_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_ack_o(p1_ack_o), .p1_err_o(p1_err_o), .p1_rdata_o(p1_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int viol = 0;
  logic [7:0] mem [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  logic [31:0] held0, held1;
  exp_t sb0[$], sb1[$];
  beat_t beats[$];

  always @(posedge clk) cyc <= cyc + 1;

  // byte memory: known pattern at the first edge, then commits writes on the strobe edge
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'(i * 13 + 5);
    end else if (mem_write_o) begin
      mem[mem_addr_o[4:0]] <= mem_wdata_o[7:0];
    end
  end
  assign mem_rdata_i = {24'hA5C35A, mem[mem_addr_o[4:0]]};

  // beat log and strobe/err rule watch
  always @(posedge clk) begin
    if (cyc > 1) begin
      if (mem_read_o || mem_write_o)
        beats.push_back('{cyc, mem_write_o, mem_addr_o, mem_write_o ? mem_wdata_o[7:0] : mem_rdata_i[7:0]});
      if ((mem_read_o && mem_write_o) || (mem_wdata_o[31:8] !== 24'b0) ||
          (!(mem_read_o || mem_write_o) && (mem_addr_o !== 32'b0 || mem_wdata_o !== 32'b0)) ||
          (p0_err_o && !p0_ack_o) || (p1_err_o && !p1_ack_o))
        viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    logic bad_a;
    bad_a = (addr[1:0] != 2'b00) || (addr > 32'(MEM_BYTES - 4));
    e.err = bad_a;
    e.rdata = (port == 0) ? held0 : held1;
    if (!bad_a && !we)
      e.rdata = {ref_mem[5'(addr + 32'd3)], ref_mem[5'(addr + 32'd2)], ref_mem[5'(addr + 32'd1)], ref_mem[5'(addr)]};
    if (!bad_a && we)
      for (int j = 0; j < 4; j++) ref_mem[5'(addr + 32'(j))] = wdata[8*j +: 8];
    if (port == 0) begin
      held0 = e.rdata; sb0.push_back(e);
      p0_req_i = 1'b1; p0_we_i = we; p0_addr_i = addr; p0_wdata_i = wdata;
    end else begin
      held1 = e.rdata; sb1.push_back(e);
      p1_req_i = 1'b1; p1_we_i = we; p1_addr_i = addr; p1_wdata_i = wdata;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    p0_req_i = 0; p0_we_i = 0; p0_addr_i = 0; p0_wdata_i = 0;
    p1_req_i = 0; p1_we_i = 0; p1_addr_i = 0; p1_wdata_i = 0;
    tick(); tick();
    total++;
    if ({p0_ack_o, p0_err_o, p0_rdata_o, p1_ack_o, p1_err_o, p1_rdata_o, mem_addr_o,
         mem_write_o, mem_read_o, mem_wdata_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got p0_rdata=%h p1_rdata=%h mem_addr=%h busy=%b, want all zero",
               p0_rdata_o, p1_rdata_o, mem_addr_o, busy_o);
    end
    rst_i = 1'b0;
    held0 = '0; held1 = '0;
    tick();
  endtask

  task automatic test_single(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int b0, c0, lat, nb, exp_lat;
    exp_t e;
    logic bad_a, ack;
    logic [32:0] got;
    logic [31:0] rd, hold_exp;
    logic [72:0] gb, eb;
    bad_a = (addr[1:0] != 2'b00) || (addr > 32'(MEM_BYTES - 4));
    exp_lat = bad_a ? 1 : 5;
    b0 = beats.size(); c0 = cyc; lat = -1;
    issue(port, we, addr, wdata);
    hold_exp = (port == 0) ? held0 : held1;
    while (lat < 0 && cyc - c0 < 12) begin
      tick();
      ack = (port == 0) ? p0_ack_o : p1_ack_o;
      if (ack) begin
        lat = cyc - c0;
        if (port == 0) begin e = sb0.pop_front(); p0_req_i = 1'b0; got = {p0_err_o, p0_rdata_o}; end
        else           begin e = sb1.pop_front(); p1_req_i = 1'b0; got = {p1_err_o, p1_rdata_o}; end
        total++;
        if (got !== {e.err, e.rdata}) begin
          bad++;
          $display("FAIL ack_payload p%0d addr=%h: got err=%b rdata=%h, want err=%b rdata=%h",
                   port, addr, got[32], got[31:0], e.err, e.rdata);
        end
      end
    end
    if (lat < 0) begin p0_req_i = 1'b0; p1_req_i = 1'b0; sb0.delete(); sb1.delete(); end
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL ack_latency p%0d addr=%h: got %0d cycles, want %0d", port, addr, lat, exp_lat);
    end
    tick(); tick();
    nb = beats.size() - b0;
    total++;
    if (nb != (bad_a ? 0 : 4)) begin
      bad++;
      $display("FAIL beat_count p%0d addr=%h: got %0d beats, want %0d", port, addr, nb, bad_a ? 0 : 4);
    end else begin
      for (int j = 0; j < nb; j++) begin
        gb = {beats[b0+j].we, beats[b0+j].addr, beats[b0+j].data, 32'(beats[b0+j].cyc - c0)};
        eb = {we, addr + 32'(j), ref_mem[5'(addr + 32'(j))], 32'(j + 1)};
        total++;
        if (gb !== eb) begin
          bad++;
          $display("FAIL beat%0d p%0d: got we=%b addr=%h data=%h cyc=%0d, want we=%b addr=%h data=%h cyc=%0d",
                   j, port, gb[72], gb[71:40], gb[39:32], gb[31:0], eb[72], eb[71:40], eb[39:32], eb[31:0]);
        end
      end
    end
    rd = (port == 0) ? p0_rdata_o : p1_rdata_o;
    total++;
    if (rd !== hold_exp) begin
      bad++;
      $display("FAIL rdata_hold p%0d: got %h, want %h", port, rd, hold_exp);
    end
  endtask

  task automatic test_contention(input int first);
    int c0, l0, l1, e0, e1;
    exp_t e;
    c0 = cyc; l0 = -1; l1 = -1;
    e0 = (first == 0) ? 5 : 11;
    e1 = (first == 0) ? 11 : 5;
    issue(0, 1'b0, 32'd4, 32'd0);
    issue(1, 1'b0, 32'd28, 32'd0);
    while ((l0 < 0 || l1 < 0) && cyc - c0 < 20) begin
      tick();
      if (p0_ack_o && l0 < 0) begin
        l0 = cyc - c0; p0_req_i = 1'b0; e = sb0.pop_front();
        total++;
        if ({p0_err_o, p0_rdata_o} !== {e.err, e.rdata}) begin
          bad++;
          $display("FAIL contention_p0: got err=%b rdata=%h, want err=%b rdata=%h", p0_err_o, p0_rdata_o, e.err, e.rdata);
        end
      end
      if (p1_ack_o && l1 < 0) begin
        l1 = cyc - c0; p1_req_i = 1'b0; e = sb1.pop_front();
        total++;
        if ({p1_err_o, p1_rdata_o} !== {e.err, e.rdata}) begin
          bad++;
          $display("FAIL contention_p1: got err=%b rdata=%h, want err=%b rdata=%h", p1_err_o, p1_rdata_o, e.err, e.rdata);
        end
      end
    end
    p0_req_i = 1'b0; p1_req_i = 1'b0; sb0.delete(); sb1.delete();
    total++;
    if (l0 != e0 || l1 != e1) begin
      bad++;
      $display("FAIL contention_order: got p0=%0d p1=%0d, want p0=%0d p1=%0d", l0, l1, e0, e1);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int b0, acks;
    b0 = beats.size();
    p0_req_i = 1'b1; p0_we_i = 1'b1; p0_addr_i = 32'd8; p0_wdata_i = 32'h11223344;
    tick(); tick();
    rst_i = 1'b1; p0_req_i = 1'b0;
    tick();
    total++;
    if ({p0_ack_o, p0_err_o, p0_rdata_o, p1_ack_o, p1_err_o, p1_rdata_o, mem_addr_o,
         mem_write_o, mem_read_o, mem_wdata_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got p1_rdata=%h mem_addr=%h write=%b busy=%b, want all zero",
               p1_rdata_o, mem_addr_o, mem_write_o, busy_o);
    end
    rst_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks += int'(p0_ack_o | p1_ack_o);
    end
    total++;
    if (acks != 0 || beats.size() - b0 != 2) begin
      bad++;
      $display("FAIL midreset_abort: got acks=%0d beats=%0d, want acks=0 beats=2", acks, beats.size() - b0);
    end
    ref_mem[8] = 8'h44; ref_mem[9] = 8'h33;
    held0 = '0; held1 = '0;
    test_single(0, 1'b0, 32'd8, 32'd0);
  endtask

  task automatic test_holdoff();
    int b0, c0, l0, l1, ec;
    exp_t e;
    logic [72:0] gb, eb;
    logic [31:0] ea;
    logic ew;
    b0 = beats.size(); c0 = cyc; l0 = -1; l1 = -1;
    issue(0, 1'b1, 32'd12, 32'h55667788);
    tick();
    issue(1, 1'b0, 32'd4, 32'd0);
    tick();
    p0_addr_i = 32'd20; p0_we_i = 1'b0; p0_wdata_i = '1;
    while ((l0 < 0 || l1 < 0) && cyc - c0 < 20) begin
      tick();
      if (p0_ack_o && l0 < 0) begin
        l0 = cyc - c0; p0_req_i = 1'b0; e = sb0.pop_front();
        total++;
        if ({p0_err_o, p0_rdata_o} !== {e.err, e.rdata}) begin
          bad++;
          $display("FAIL holdoff_p0: got err=%b rdata=%h, want err=%b rdata=%h", p0_err_o, p0_rdata_o, e.err, e.rdata);
        end
      end
      if (p1_ack_o && l1 < 0) begin
        l1 = cyc - c0; p1_req_i = 1'b0; e = sb1.pop_front();
        total++;
        if ({p1_err_o, p1_rdata_o} !== {e.err, e.rdata}) begin
          bad++;
          $display("FAIL holdoff_p1: got err=%b rdata=%h, want err=%b rdata=%h", p1_err_o, p1_rdata_o, e.err, e.rdata);
        end
      end
    end
    p0_req_i = 1'b0; p1_req_i = 1'b0; sb0.delete(); sb1.delete();
    total++;
    if (l0 != 5 || l1 != 11) begin
      bad++;
      $display("FAIL holdoff_timing: got p0=%0d p1=%0d, want p0=5 p1=11", l0, l1);
    end
    tick();
    total++;
    if (beats.size() - b0 != 8) begin
      bad++;
      $display("FAIL holdoff_beat_count: got %0d, want 8", beats.size() - b0);
    end else begin
      for (int j = 0; j < 8; j++) begin
        ew = (j < 4);
        ea = ew ? 32'(12 + j) : 32'(j);
        ec = ew ? j + 1 : j + 3;
        gb = {beats[b0+j].we, beats[b0+j].addr, beats[b0+j].data, 32'(beats[b0+j].cyc - c0)};
        eb = {ew, ea, ref_mem[5'(ea)], 32'(ec)};
        total++;
        if (gb !== eb) begin
          bad++;
          $display("FAIL holdoff_beat%0d: got we=%b addr=%h data=%h cyc=%0d, want we=%b addr=%h data=%h cyc=%0d",
                   j, gb[72], gb[71:40], gb[39:32], gb[31:0], eb[72], eb[71:40], eb[39:32], eb[31:0]);
        end
      end
    end
  endtask

  task automatic test_strobes();
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL strobe_rules: got %0d violating cycles, want 0", viol);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'(i * 13 + 5);
    held0 = '0; held1 = '0;
    test_reset();
    test_single(0, 1'b1, 32'd4,  32'hA1B2C3D4);
    test_single(1, 1'b1, 32'd28, 32'hCAFEF00D);
    test_single(0, 1'b0, 32'd4,  32'd0);
    test_single(1, 1'b0, 32'd28, 32'd0);
    test_reset();
    test_contention(0);
    test_single(0, 1'b0, 32'd4, 32'd0);
    test_contention(1);
    test_single(1, 1'b1, 32'd6,         32'h12345678);
    test_single(1, 1'b0, 32'd32,        32'd0);
    test_single(0, 1'b0, 32'h0000_0100, 32'd0);
    test_single(0, 1'b1, 32'hFFFF_FFFC, 32'h0BADBEEF);
    test_single(0, 1'b1, 32'd28,        32'h0BADBEEF);
    test_single(1, 1'b0, 32'd28,        32'd0);
    test_reset_mid();
    test_holdoff();
    test_strobes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
